// File: rtl/i2c_glitch_filter.sv
// Two-line I2C input conditioner: synchronizes SCL/SDA, rejects pulses shorter than
// FILTER_LEN clocks, and flags filtered SCL edges plus START/STOP conditions.
module i2c_glitch_filter #(
   parameter int FILTER_LEN = 4,
   parameter int CNT_W      = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             scl_i,
   input  logic             sda_i,
   input  logic             filter_en_i,
   input  logic             glitch_cnt_clr_i,
   output logic             scl_o,
   output logic             sda_o,
   output logic             scl_rise_o,
   output logic             scl_fall_o,
   output logic             start_o,
   output logic             stop_o,
   output logic [CNT_W-1:0] glitch_cnt_o
);

   localparam int              CW      = $clog2(FILTER_LEN);
   localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER_LEN - 1);
   localparam logic [CNT_W:0]  GMAX    = {1'b0, {CNT_W{1'b1}}};

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, base} + (CNT_W+1)'(inc);
      return (sum > GMAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // Bit 0 carries SCL, bit 1 carries SDA throughout.
   logic [1:0]         raw;
   logic [1:0]         sync1;
   logic [1:0]         sync2;
   logic [1:0]         filt;
   logic [1:0]         filt_nxt;
   logic [1:0]         rej;
   logic [1:0]         rej_sum;
   logic [1:0][CW-1:0] cnt;
   logic [1:0][CW-1:0] cnt_nxt;

   assign raw = {sda_i, scl_i};

   always_comb begin
      filt_nxt = filt;
      rej      = '0;
      cnt_nxt  = '0;
      for (int i = 0; i < 2; i++) begin
         if (!filter_en_i) begin
            filt_nxt[i] = sync2[i];
         end else if (sync2[i] == filt[i]) begin
            // A run that ends before reaching FILTER_LEN is a rejected glitch.
            rej[i] = (cnt[i] != '0);
         end else if (cnt[i] == CNT_MAX) begin
            filt_nxt[i] = ~filt[i];
         end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
         end
      end
   end

   assign rej_sum = {1'b0, rej[0]} + {1'b0, rej[1]};

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         sync1        <= '1;
         sync2        <= '1;
         filt         <= '1;
         cnt          <= '0;
         scl_rise_o   <= 1'b0;
         scl_fall_o   <= 1'b0;
         start_o      <= 1'b0;
         stop_o       <= 1'b0;
         glitch_cnt_o <= '0;
      end else begin
         sync1      <= raw;
         sync2      <= sync1;
         filt       <= filt_nxt;
         cnt        <= cnt_nxt;
         scl_rise_o <= filt_nxt[0] & ~filt[0];
         scl_fall_o <= ~filt_nxt[0] & filt[0];
         // START/STOP only when SCL stays high across the same update.
         start_o    <= filt[1] & ~filt_nxt[1] & filt[0] & filt_nxt[0];
         stop_o     <= ~filt[1] & filt_nxt[1] & filt[0] & filt_nxt[0];
         if (glitch_cnt_clr_i)
            glitch_cnt_o <= '0;
         else
            glitch_cnt_o <= sat_add(glitch_cnt_o, rej_sum);
      end
   end

   assign scl_o = filt[0];
   assign sda_o = filt[1];

endmodule

// File: tb/tb_i2c_glitch_filter.sv
// Bench for i2c_glitch_filter: directed scenarios plus randomized traffic checked
// against a history-window reference model and against the clean I2C waveform.
module tb_i2c_glitch_filter;

   localparam int FL   = 4;
   localparam int CW   = 2;
   localparam int GMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          scl_in = 1'b1;
   logic          sda_in = 1'b1;
   logic          en = 1'b1;
   logic          clr = 1'b0;
   logic          scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o;
   logic [CW-1:0] glitch_cnt_o;

   int n_cmp = 0;
   int n_err = 0;
   int p_rise, p_fall, p_start, p_stop, p_sda_low;

   always #5 clk = ~clk;

   i2c_glitch_filter #(.FILTER_LEN(FL), .CNT_W(CW)) dut (
      .wb_clk_i        (clk),
      .wb_rst_n_i      (rst_n),
      .scl_i           (scl_in),
      .sda_i           (sda_in),
      .filter_en_i     (en),
      .glitch_cnt_clr_i(clr),
      .scl_o           (scl_o),
      .sda_o           (sda_o),
      .scl_rise_o      (scl_rise_o),
      .scl_fall_o      (scl_fall_o),
      .start_o         (start_o),
      .stop_o          (stop_o),
      .glitch_cnt_o    (glitch_cnt_o)
   );

   // Reference model: a line's output flips once its synchronized level has disagreed
   // with it on FL consecutive enabled edges; a shorter disagreement is one glitch.
   typedef struct {logic en; logic [1:0] s2;} hent_t;
   hent_t      hq[$];
   logic [1:0] m_r1, m_r2, m_out;
   logic       m_rise, m_fall, m_start, m_stop;
   int         m_gcnt;

   function automatic void model_reset();
      hq.delete();
      m_r1 = 2'b11; m_r2 = 2'b11; m_out = 2'b11;
      m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
      m_gcnt = 0;
   endfunction

   function automatic void model_edge(input logic [1:0] raw, input logic e, input logic c);
      logic [1:0] s2 = m_r2;
      logic [1:0] nw = m_out;
      int         rej = 0;
      hent_t      ent;
      ent.en = e; ent.s2 = s2;
      hq.push_front(ent);
      if (hq.size() > FL) void'(hq.pop_back());
      for (int i = 0; i < 2; i++) begin
         if (!e) nw[i] = s2[i];
         else if (s2[i] == m_out[i]) begin
            if (hq.size() > 1 && hq[1].en && hq[1].s2[i] != m_out[i]) rej++;
         end else begin
            int run = 0;
            for (int k = 0; k < hq.size(); k++) begin
               if (hq[k].en && hq[k].s2[i] != m_out[i]) run++;
               else break;
            end
            if (run >= FL) nw[i] = ~m_out[i];
         end
      end
      m_gcnt  = c ? 0 : ((m_gcnt + rej > GMAX) ? GMAX : m_gcnt + rej);
      m_rise  = nw[0] & ~m_out[0];
      m_fall  = ~nw[0] & m_out[0];
      m_start = m_out[1] & ~nw[1] & m_out[0] & nw[0];
      m_stop  = ~m_out[1] & nw[1] & m_out[0] & nw[0];
      m_out   = nw;
      m_r2    = m_r1;
      m_r1    = raw;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input logic a, input logic b);
      scl_in = a; sda_in = b;
      @(posedge clk);
      model_edge({b, a}, en, clr);
      #1;
      chk("scl_o", scl_o, m_out[0]);
      chk("sda_o", sda_o, m_out[1]);
      chk("scl_rise_o", scl_rise_o, m_rise);
      chk("scl_fall_o", scl_fall_o, m_fall);
      chk("start_o", start_o, m_start);
      chk("stop_o", stop_o, m_stop);
      chk("glitch_cnt_o", glitch_cnt_o, m_gcnt);
      p_rise  += scl_rise_o; p_fall += scl_fall_o;
      p_start += start_o;    p_stop += stop_o;
      if (sda_o == 1'b0) p_sda_low++;
      @(negedge clk);
   endtask

   task automatic clr_pulses();
      p_rise = 0; p_fall = 0; p_start = 0; p_stop = 0; p_sda_low = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_scl_o"}, scl_o, 1);
      chk({tag, "_sda_o"}, sda_o, 1);
      chk({tag, "_rise"}, scl_rise_o, 0);
      chk({tag, "_fall"}, scl_fall_o, 0);
      chk({tag, "_start"}, start_o, 0);
      chk({tag, "_stop"}, stop_o, 0);
      chk({tag, "_gcnt"}, glitch_cnt_o, 0);
   endtask

   task automatic clear_cnt();
      clr = 1'b1; tick(1, 1); clr = 1'b0;
   endtask

   function automatic bit stable(input logic q[$], input int lo, input int hi);
      if (lo < 0 || hi >= q.size()) return 0;
      for (int k = lo; k <= hi; k++) if (q[k] !== q[lo]) return 0;
      return 1;
   endfunction

   logic cs[$], cd[$], gs[$], gd[$];

   task automatic push(input logic a, input logic b, input int n);
      for (int k = 0; k < n; k++) begin cs.push_back(a); cd.push_back(b); end
   endtask

   initial begin
      logic [7:0] byte_v;
      logic       prev, v;
      int         e_rise, e_fall, e_start, e_stop, t, len;

      // Reset state
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) tick(1, 1);

      // 3-clock SDA glitch with SCL high is rejected and counted once
      clear_cnt(); clr_pulses();
      for (int k = 0; k < 3; k++) tick(1, 0);
      for (int k = 0; k < 6; k++) tick(1, 1);
      chk("short_sda_low_seen", p_sda_low, 0);
      chk("short_start_cnt", p_start, 0);
      chk("short_gcnt", glitch_cnt_o, 1);

      // Held SDA fall propagates at edge 5 after capture and makes a START
      clear_cnt(); clr_pulses();
      for (int k = 0; k < 10; k++) begin
         tick(1, 0);
         if (k == 4) chk("start_sda_before", sda_o, 1);
         if (k == 5) begin chk("start_sda_at5", sda_o, 0); chk("start_pulse_at5", start_o, 1); end
      end
      chk("start_cnt", p_start, 1);
      chk("start_gcnt", glitch_cnt_o, 0);
      for (int k = 0; k < 8; k++) tick(1, 1);

      // Simultaneous SCL/SDA toggles: edge pulses only, no START/STOP
      clr_pulses();
      for (int k = 0; k < 8; k++) tick(0, 0);
      for (int k = 0; k < 8; k++) tick(1, 1);
      chk("simul_start", p_start, 0);
      chk("simul_stop", p_stop, 0);
      chk("simul_fall", p_fall, 1);
      chk("simul_rise", p_rise, 1);

      // Same-clock rejections on both lines add 2
      clear_cnt();
      tick(0, 0);
      for (int k = 0; k < 4; k++) tick(1, 1);
      chk("dual_reject_gcnt", glitch_cnt_o, 2);

      // Saturation at 3, then clear wins over a coincident rejection
      clear_cnt();
      for (int g = 0; g < 5; g++) begin
         tick(0, 1);
         for (int k = 0; k < 3; k++) tick(1, 1);
      end
      chk("sat_gcnt", glitch_cnt_o, 3);
      tick(0, 1); tick(1, 1); tick(1, 1);
      chk("sat_gcnt_before_clr", glitch_cnt_o, 3);
      clr = 1'b1; tick(1, 1); clr = 1'b0;
      chk("clr_wins_gcnt", glitch_cnt_o, 0);
      tick(1, 1);

      // Bypass: a 1-clock SCL pulse appears 2 clocks after capture; count holds
      tick(0, 1);
      for (int k = 0; k < 3; k++) tick(1, 1);
      chk("pre_bypass_gcnt", glitch_cnt_o, 1);
      en = 1'b0; clr_pulses();
      tick(1, 1); tick(1, 1);
      tick(0, 1);
      tick(1, 1); chk("byp_scl_idx1", scl_o, 1);
      tick(1, 1); chk("byp_scl_idx2", scl_o, 0); chk("byp_fall_idx2", scl_fall_o, 1);
      tick(1, 1); chk("byp_scl_idx3", scl_o, 1); chk("byp_rise_idx3", scl_rise_o, 1);
      tick(1, 1);
      chk("byp_rise_cnt", p_rise, 1);
      chk("byp_fall_cnt", p_fall, 1);
      chk("byp_gcnt_hold", glitch_cnt_o, 1);

      // Disabling the filter on the edge a glitch would be counted drops it silently
      en = 1'b1; clr_pulses();
      for (int k = 0; k < 3; k++) tick(1, 1);
      for (int k = 0; k < 3; k++) tick(1, 0);
      tick(1, 1); tick(1, 1);
      en = 1'b0; tick(1, 1); en = 1'b1;
      for (int k = 0; k < 4; k++) tick(1, 1);
      chk("toggle_en_gcnt", glitch_cnt_o, 1);
      chk("toggle_en_sda_low", p_sda_low, 0);

      // Reset mid-filtering with the SDA counter at 2
      for (int k = 0; k < 4; k++) tick(1, 0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      model_reset();
      sda_in = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; clr_pulses();
      for (int k = 0; k < 8; k++) tick(1, 1);
      chk("postrst_pulses", p_rise + p_fall + p_start + p_stop, 0);
      chk("postrst_gcnt", glitch_cnt_o, 0);

      // Full byte transfer at SCL period 40 under random short glitches
      byte_v = 8'($urandom_range(0, 255));
      push(1, 1, 20); push(1, 0, 20);
      prev = 1'b0;
      for (int b = 0; b < 9; b++) begin
         v = (b < 8) ? byte_v[7 - b] : 1'b0;
         push(0, prev, 10); push(0, v, 10); push(1, v, 20);
         prev = v;
      end
      push(0, prev, 10); push(0, 0, 10); push(1, 0, 10); push(1, 1, 30);
      gs = cs; gd = cd;
      t = 6;
      while (t < cs.size()) begin
         len = $urandom_range(1, 3);
         if (stable(cs, t - 6, t + len + 6) && $urandom_range(0, 3) == 0) begin
            for (int k = 0; k < len; k++) gs[t + k] = ~cs[t + k];
            t += len + 2;
         end else t++;
      end
      t = 6;
      while (t < cd.size()) begin
         len = $urandom_range(1, 3);
         if (stable(cd, t - 6, t + len + 6) && $urandom_range(0, 3) == 0) begin
            for (int k = 0; k < len; k++) gd[t + k] = ~cd[t + k];
            t += len + 2;
         end else t++;
      end
      e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0;
      for (int k = 1; k < cs.size(); k++) begin
         if (!cs[k-1] && cs[k]) e_rise++;
         if (cs[k-1] && !cs[k]) e_fall++;
         if (cd[k-1] && !cd[k] && cs[k-1] && cs[k]) e_start++;
         if (!cd[k-1] && cd[k] && cs[k-1] && cs[k]) e_stop++;
      end
      clear_cnt();
      for (int k = 0; k < 8; k++) tick(1, 1);
      clr_pulses();
      for (int k = 0; k < cs.size(); k++) begin
         tick(gs[k], gd[k]);
         chk("clean_scl", scl_o, (k >= FL + 1) ? cs[k - FL - 1] : 1'b1);
         chk("clean_sda", sda_o, (k >= FL + 1) ? cd[k - FL - 1] : 1'b1);
      end
      chk("byte_rise_cnt", p_rise, e_rise);
      chk("byte_fall_cnt", p_fall, e_fall);
      chk("byte_start_cnt", p_start, e_start);
      chk("byte_stop_cnt", p_stop, e_stop);

      // Free-running random traffic with occasional bypass and clear
      scl_in = 1'b1; sda_in = 1'b1;
      for (int k = 0; k < 400; k++) begin
         en  = ($urandom_range(0, 15) != 0);
         clr = ($urandom_range(0, 31) == 0);
         tick(($urandom_range(0, 3) == 0) ? ~scl_in : scl_in,
              ($urandom_range(0, 3) == 0) ? ~sda_in : sda_in);
      end
      en = 1'b1; clr = 1'b0;
      for (int k = 0; k < 10; k++) tick(1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
